// File: rtl/aes_ctr_multilane.sv
// Multi-lane AES-128 CTR engine: LANES counter blocks per beat, AES_LAT-cycle core latency, credit-guarded output FIFO.
// Optional counter-wrap guard (HALT state, ctr_wrap flag) enabled by defining AES_CTR_WRAP_GUARD_EN.
module aes_ctr_multilane #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned AES_LAT = 20,
    parameter int unsigned DEPTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_load,
    input  logic [127:0]           cfg_key,
    input  logic [63:0]            cfg_nonce,
    input  logic [63:0]            cfg_ctr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*128-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*128-1:0]   out_data,
    output logic                   ctr_wrap
);
    localparam int unsigned DW = LANES * 128;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

`ifdef AES_CTR_WRAP_GUARD_EN
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
`else
    typedef enum logic [0:0] {IDLE, RUN} state_t;
`endif

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (last) begin
                o[127-32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                     xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
            end
        end
        return o ^ rk;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    state_t          state_q, state_d;
    logic [127:0]    key_q;
    logic [63:0]     nonce_q, ctr_q;
    logic [CW-1:0]   used_q, used_d, cnt_q, cnt_d;
    logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic            in_ready_d, out_valid_d;
    logic [DW-1:0]   out_data_d;
    logic [127:0]    rk [11];
    logic [DW-1:0]   ks;
    logic [DW-1:0]   pipe_data [AES_LAT];
    logic [AES_LAT-1:0] pipe_vld;
    logic [DW-1:0]   mem [DEPTH];
    logic            accept, pop, push;
    logic [DW-1:0]   push_data;

    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign push      = pipe_vld[AES_LAT-1];
    assign push_data = pipe_data[AES_LAT-1];

    // Round-key schedule, recomputed only when the key register changes
    always_comb begin
        logic [31:0] w0, w1, w2, w3;
        logic [7:0]  rc;
        rk[0]            = key_q;
        rc               = 8'h01;
        {w0, w1, w2, w3} = key_q;
        for (int r = 1; r < 11; r++) begin
            w0    = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
            w1    = w1 ^ w0;
            w2    = w2 ^ w1;
            w3    = w3 ^ w2;
            rk[r] = {w0, w1, w2, w3};
            rc    = xt(rc);
        end
    end

    // Keystream for the beat currently offered: lane i encrypts {nonce, ctr+i}
    always_comb begin
        logic [127:0] s;
        ks = '0;
        for (int i = 0; i < LANES; i++) begin
            s = {nonce_q, ctr_q + 64'(i)} ^ rk[0];
            for (int r = 1; r < 10; r++) s = aes_round(s, rk[r], 1'b0);
            ks[i*128 +: 128] = aes_round(s, rk[10], 1'b1);
        end
    end

`ifdef AES_CTR_WRAP_GUARD_EN
    logic wrap_hit, wrap_q, wrap_d;
    assign wrap_hit = ctr_q > (64'hFFFF_FFFF_FFFF_FFFF - 64'(LANES - 1));
    assign ctr_wrap = wrap_q;
`else
    assign ctr_wrap = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        used_d  = used_q + CW'(accept) - CW'(pop);
        cnt_d   = cnt_q + CW'(push) - CW'(pop);
        rd_d    = pop ? ptr_inc(rd_q) : rd_q;
        wr_d    = push ? ptr_inc(wr_q) : wr_q;
`ifdef AES_CTR_WRAP_GUARD_EN
        wrap_d  = wrap_q;
        if (cfg_load)                  wrap_d = 1'b0;
        else if (accept && wrap_hit)   wrap_d = 1'b1;
`endif
        case (state_q)
            IDLE: if (cfg_load) state_d = RUN;
            RUN: begin
`ifdef AES_CTR_WRAP_GUARD_EN
                if (!cfg_load && accept && wrap_hit) state_d = HALT;
`endif
            end
`ifdef AES_CTR_WRAP_GUARD_EN
            HALT: if (cfg_load) state_d = RUN;
`endif
            default: state_d = IDLE;
        endcase
        // Credit covers in-flight plus buffered beats so the pipeline never stalls
        in_ready_d  = (state_d == RUN) && (used_d < CW'(DEPTH));
        out_valid_d = (cnt_d != '0);
        if (cnt_d == '0)              out_data_d = '0;
        else if (cnt_q == CW'(pop))   out_data_d = push_data;
        else                          out_data_d = mem[rd_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            key_q     <= '0;
            nonce_q   <= '0;
            ctr_q     <= '0;
            used_q    <= '0;
            cnt_q     <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            pipe_vld  <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef AES_CTR_WRAP_GUARD_EN
            wrap_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            used_q    <= used_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
`ifdef AES_CTR_WRAP_GUARD_EN
            wrap_q    <= wrap_d;
`endif
            pipe_vld[0] <= accept;
            for (int i = 1; i < AES_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
            if (cfg_load) begin
                key_q   <= cfg_key;
                nonce_q <= cfg_nonce;
                ctr_q   <= cfg_ctr;
            end else if (accept) begin
                ctr_q   <= ctr_q + 64'(LANES);
            end
        end
    end

    // Data path: payload travels alongside the valid tags, FIFO storage needs no reset
    always_ff @(posedge clk) begin
        pipe_data[0] <= in_data ^ ks;
        for (int i = 1; i < AES_LAT; i++) pipe_data[i] <= pipe_data[i-1];
        if (push) mem[wr_q] <= push_data;
    end

endmodule

// File: tb/tb_aes_ctr_multilane.sv
// Randomized bench for aes_ctr_multilane against a byte-level AES-CTR reference and a beat queue.
// Honours AES_CTR_WRAP_GUARD_EN the same way as the design.
module tb_aes_ctr_multilane;
    localparam int unsigned LANES   = 4;
    localparam int unsigned AES_LAT = 20;
    localparam int unsigned DEPTH   = 32;
    localparam int unsigned DW      = LANES * 128;

    localparam logic [127:0] KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [63:0]  NONCE = 64'hf0f1f2f3f4f5f6f7;
    localparam logic [63:0]  CTR0  = 64'hf8f9fafbfcfdfeff;
    localparam logic [DW-1:0] PT = {128'hf69f2445df4f9b17ad2b417be66c3710,
                                    128'h30c81c46a35ce411e5fbc1191a0a52ef,
                                    128'hae2d8a571e03ac9c9eb76fac45af8e51,
                                    128'h6bc1bee22e409f96e93d7e117393172a};
    localparam logic [DW-1:0] CT = {128'h1e031dda2fbe03d1792170a0f3009cee,
                                    128'h5ae4df3edbd5d35e5b4f09020db03eab,
                                    128'h9806f66b7970fdff8617187bb9fffdff,
                                    128'h874d6191b620e3261bef6864990db6ce};

    logic          clk, rst, cfg_load, in_valid, in_ready, out_valid, out_ready, ctr_wrap;
    logic [127:0]  cfg_key;
    logic [63:0]   cfg_nonce, cfg_ctr;
    logic [DW-1:0] in_data, out_data;

    aes_ctr_multilane #(.LANES(LANES), .AES_LAT(AES_LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_nonce(cfg_nonce),
        .cfg_ctr(cfg_ctr), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .ctr_wrap(ctr_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // S-box table built with the p/q log-walk generator
    logic [7:0] sb [256];
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [7:0] m2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m3(input logic [7:0] b);
        return m2(b) ^ b;
    endfunction

    function automatic logic [127:0] ref_aes(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   st [16];
        logic [7:0]   t  [16];
        logic [7:0]   rk [16];
        logic [7:0]   k4 [4];
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            st[i] = pt[127-8*i -: 8];
            rk[i] = key[127-8*i -: 8];
            st[i] = st[i] ^ rk[i];
        end
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) st[i] = sb[st[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) t[w+4*c] = st[w+4*((c+w)%4)];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    st[4*c]   = m2(t[4*c]) ^ m3(t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
                    st[4*c+1] = t[4*c] ^ m2(t[4*c+1]) ^ m3(t[4*c+2]) ^ t[4*c+3];
                    st[4*c+2] = t[4*c] ^ t[4*c+1] ^ m2(t[4*c+2]) ^ m3(t[4*c+3]);
                    st[4*c+3] = m3(t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ m2(t[4*c+3]);
                end else begin
                    for (int w = 0; w < 4; w++) st[4*c+w] = t[4*c+w];
                end
            end
            k4[0] = sb[rk[13]] ^ rc;
            k4[1] = sb[rk[14]];
            k4[2] = sb[rk[15]];
            k4[3] = sb[rk[12]];
            for (int i = 0; i < 16; i++) rk[i] = rk[i] ^ ((i < 4) ? k4[i] : rk[i-4]);
            rc = m2(rc);
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    // Reference state: configuration, mode and the queue of beats not yet delivered
    typedef struct { logic [DW-1:0] d; longint t; } exp_t;
    exp_t          q [$];
    logic [127:0]  m_key;
    logic [63:0]   m_nonce, m_ctr;
    int            m_state;   // 0 idle, 1 run, 2 halt
    logic          m_wrap;
    longint        cyc = 0;

    function automatic logic [DW-1:0] model_beat(input logic [DW-1:0] din);
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++)
            r[i*128 +: 128] = din[i*128 +: 128] ^ ref_aes(m_key, {m_nonce, m_ctr + 64'(i)});
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // One clock: score the handshakes of this cycle, advance, then check the new outputs
    task automatic tick();
        logic acc, pop, exp_ir, exp_ov;
        exp_t e;
`ifdef AES_CTR_WRAP_GUARD_EN
        logic wraps;
`endif
        acc = in_valid && in_ready && !rst;
        pop = out_valid && out_ready && !rst;
        if (pop) begin
            if (q.size() == 0) check("pop_empty", DW'(out_valid), '0);
            else begin
                check("out_data", out_data, q[0].d);
                q.delete(0);
            end
        end
        if (rst) begin
            q.delete();
            m_state = 0; m_wrap = 1'b0;
            m_key = '0; m_nonce = '0; m_ctr = '0;
        end else begin
            if (acc) begin
                e.d = model_beat(in_data);
                e.t = cyc;
                q.push_back(e);
`ifdef AES_CTR_WRAP_GUARD_EN
                wraps = ({1'b0, m_ctr} + 65'(LANES - 1)) >= {1'b1, 64'h0};
                if (wraps && !cfg_load) begin
                    m_state = 2;
                    m_wrap  = 1'b1;
                end
`endif
                m_ctr = m_ctr + 64'(LANES);
            end
            if (cfg_load) begin
                m_key = cfg_key; m_nonce = cfg_nonce; m_ctr = cfg_ctr;
                m_state = 1; m_wrap = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        exp_ir = (m_state == 1) && (q.size() < DEPTH);
        exp_ov = (q.size() != 0) && (cyc >= q[0].t + AES_LAT + 1);
        check("in_ready", DW'(in_ready), DW'(exp_ir));
        check("out_valid", DW'(out_valid), DW'(exp_ov));
        check("ctr_wrap", DW'(ctr_wrap), DW'(m_wrap));
    endtask

    task automatic load(input logic [127:0] k, input logic [63:0] n, input logic [63:0] c);
        cfg_key = k; cfg_nonce = n; cfg_ctr = c; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic wait_valid();
        for (int k = 0; k < 64 && !out_valid; k++) tick();
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 300 && q.size() != 0; k++) tick();
        check("drain_left", DW'(q.size()), '0);
    endtask

    // Offer one beat with the output ready, return the first visible result and its latency
    task automatic run_one(input logic [DW-1:0] d, output logic [DW-1:0] res, output longint lat);
        longint t0;
        in_valid = 1'b1; in_data = d; out_ready = 1'b1;
        t0 = cyc;
        tick();
        in_valid = 1'b0;
        wait_valid();
        res = out_data;
        lat = cyc - t0;
    endtask

    initial begin
        logic [DW-1:0] res, d;
        longint        lat;
        int            n_acc;
        build_sbox();
        rst = 1'b1; cfg_load = 1'b0; cfg_key = '0; cfg_nonce = '0; cfg_ctr = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) tick();
        check("rst_out_data", out_data, '0);
        rst = 1'b0;
        tick();

        // Known-answer vector and exact latency
        load(KEY, NONCE, CTR0);
        run_one(PT, res, lat);
        check("kat_latency", DW'(lat), DW'(AES_LAT + 1));
        check("kat_ct", res, CT);
        drain();

        // Decrypt the same beat back to plaintext
        load(KEY, NONCE, CTR0);
        run_one(CT, res, lat);
        check("roundtrip_pt", res, PT);
        drain();

        // Backpressure: only DEPTH of 40 beats accepted while the output is stalled
        load(KEY, NONCE, 64'h0123_4567_89ab_cdef);
        out_ready = 1'b0; n_acc = 0;
        for (int k = 0; k < 60; k++) begin
            in_valid = 1'b1; in_data = rnd_data();
            if (in_ready) n_acc++;
            tick();
        end
        check("bp_accepts", DW'(n_acc), DW'(DEPTH));
        out_ready = 1'b1;
        for (int k = 0; k < 200 && n_acc < 40; k++) begin
            in_valid = 1'b1; in_data = rnd_data();
            if (in_ready) n_acc++;
            tick();
        end
        in_valid = 1'b0;
        check("bp_total", DW'(n_acc), DW'(40));
        drain();

        // Counter wrap inside one beat
        load(KEY, NONCE, 64'hffff_ffff_ffff_fffe);
        d = rnd_data();
`ifdef AES_CTR_WRAP_GUARD_EN
        in_valid = 1'b1; in_data = d; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("wrap_flag", DW'(ctr_wrap), DW'(1));
        check("wrap_in_ready", DW'(in_ready), '0);
        drain();
        load(KEY, NONCE, 64'h0);
        check("wrap_clear_flag", DW'(ctr_wrap), '0);
        check("wrap_clear_ready", DW'(in_ready), DW'(1));
`else
        run_one(d, res, lat);
        check("wrap_lane2", DW'(res[256 +: 128]),
              DW'(d[256 +: 128] ^ ref_aes(KEY, {NONCE, 64'h0})));
        check("wrap_flag_off", DW'(ctr_wrap), '0);
        drain();
`endif

        // Reset with five beats in flight
        load(KEY, NONCE, 64'h55);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = rnd_data();
            tick();
        end
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            check("rst_flush_valid", DW'(out_valid), '0);
        end
        load(KEY, NONCE, 64'h99);
        run_one(rnd_data(), res, lat);
        check("post_rst_latency", DW'(lat), DW'(AES_LAT + 1));
        drain();

        // Randomized traffic with occasional reloads and resets
        for (int k = 0; k < 1500; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = rnd_data();
            cfg_load  = ($urandom_range(0, 60) == 0);
            cfg_key   = {$urandom, $urandom, $urandom, $urandom};
            cfg_nonce = {$urandom, $urandom};
            cfg_ctr   = {$urandom, $urandom};
            rst       = ($urandom_range(0, 700) == 0);
            tick();
        end
        cfg_load = 1'b0; rst = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/aes_ctr_multilane.md
AES_CTR_MULTILANE -- requirements
Module: aes_ctr_multilane

Interface
REQ-001 The block SHALL have parameter LANES, default 4, giving the number of parallel 128-bit AES-128 CTR lanes (1..8).
REQ-002 The block SHALL have parameter AES_LAT, default 20, giving the clock latency of one pipelined aes_128 core instance.
REQ-003 The block SHALL have parameter DEPTH, default 32, giving the output FIFO depth in beats, with DEPTH >= AES_LAT+2.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have the ports cfg_load (input, 1), cfg_key (input, 128), cfg_nonce (input, 64) and cfg_ctr (input, 64): the key, nonce and initial counter load.
REQ-007 The block SHALL have the ports in_valid (input, 1), in_ready (output, 1) and in_data (input, LANES*128): input beats; lane i is in_data[i*128 +: 128].
REQ-008 The block SHALL have the ports out_valid (output, 1), out_ready (input, 1) and out_data (output, LANES*128): result beats, with the same lane packing as in_data.
REQ-009 The block SHALL have the port ctr_wrap (output, 1): sticky counter-wrap flag, active only when the macro in REQ-027 is defined.

Function
REQ-010 The block SHALL implement states IDLE, RUN and HALT, and SHALL enter IDLE on reset.
REQ-011 In IDLE, in_ready SHALL be 0; cfg_load=1 SHALL register the key, nonce and counter and move the state to RUN on the next cycle.
REQ-012 A beat SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-013 For an accepted beat, lane i SHALL encrypt the block {nonce, ctr+i}, with the 64-bit addition taken modulo 2^64.
REQ-014 After each accepted beat, ctr SHALL advance by LANES modulo 2^64.
REQ-015 out_data lane i SHALL equal AES128(key, {nonce, ctr+i}) XOR the in_data lane i of the same beat.
- Encryption and decryption use the same path.
REQ-016 in_data SHALL be delayed by AES_LAT cycles in step with the cores so that each result is matched to its own beat.
REQ-017 in_ready SHALL be 1 in RUN only when (beats in flight + FIFO occupancy) < DEPTH; no beat SHALL ever be dropped.
REQ-018 With the FIFO empty and out_ready=1, a beat accepted at cycle t SHALL present out_valid=1 at cycle t+AES_LAT+1.
REQ-019 Beats SHALL leave in acceptance order, each exactly once.
REQ-020 A beat leaves on a cycle with out_valid=1 and out_ready=1.
- While out_ready=0, out_data SHALL hold stable.
REQ-021 With the FIFO full and a pop and a push on the same cycle, both SHALL succeed and occupancy SHALL stay at DEPTH.
REQ-022 cfg_load in RUN SHALL take effect for beats accepted from the next cycle; beats already accepted SHALL complete with the old key, nonce and counter.
REQ-023 cfg_load and an input accept on the same cycle: the beat SHALL use the old values.

Reset
REQ-024 On rst=1, out_valid, in_ready and ctr_wrap SHALL be 0, and out_data, key, nonce and ctr SHALL be 0.
REQ-025 On rst=1, the FIFO and the in-flight tags SHALL be cleared and the state SHALL be IDLE.
REQ-026 A reset asserted mid-operation SHALL discard all in-flight and buffered beats, with no output on the cycle after reset.

Configuration
REQ-027 When AES_CTR_WRAP_GUARD_EN is defined, an accepted beat in which any ctr+i (0 <= i < LANES) reaches 2^64 SHALL set ctr_wrap=1 and move the state to HALT.
- That beat still completes.
REQ-028 In HALT, in_ready SHALL be 0 and the FIFO SHALL continue draining.
- cfg_load SHALL clear ctr_wrap and return the state to RUN.
REQ-029 When AES_CTR_WRAP_GUARD_EN is undefined, ctr_wrap SHALL be tied to 0, the HALT state SHALL be absent, and the counter SHALL wrap silently.

Verification
REQ-030 Vector test: LANES=4, key 2b7e151628aed2a6abf7158809cf4f3c, nonce f0f1f2f3f4f5f6f7, ctr f8f9fafbfcfdfeff.
- Stimulus (lanes 0-3): 6bc1bee22e409f96e93d7e117393172a, ae2d8a571e03ac9c9eb76fac45af8e51, 30c81c46a35ce411e5fbc1191a0a52ef, f69f2445df4f9b17ad2b417be66c3710.
- Required response (lanes 0-3): 874d6191b620e3261bef6864990db6ce, 9806f66b7970fdff8617187bb9fffdff, 5ae4df3edbd5d35e5b4f09020db03eab, 1e031dda2fbe03d1792170a0f3009cee.
- out_valid SHALL rise exactly AES_LAT+1 cycles after the accept.
REQ-031 Round trip: feed the REQ-030 ciphertext back in after a cfg_load of the same values -> the REQ-030 plaintext is returned.
REQ-032 Backpressure: out_ready=0 with 40 beats offered -> in_ready falls after DEPTH accepts; all 40 beats appear in order with none lost or duplicated.
REQ-033 Wrap: macro defined, ctr=fffffffffffffffe, LANES=4 -> ctr_wrap=1 and in_ready=0 after one beat; a cfg_load clears both.
REQ-034 Wrap, macro undefined: same stimulus -> lane 2 uses ctr 0 and ctr_wrap stays 0.
REQ-035 Reset mid-flight: rst=1 for 1 cycle with 5 beats in flight -> out_valid stays 0 until a cfg_load and new input are applied.
